// File: rtl/apb_master_nslv.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_nslv
// Brief    : APB master bridge with NUM_SLV-way address decode, PREADY wait
//            states, PSLVERR reporting and back-to-back transfers.
//            Optional ACCESS-phase timeout enabled by macro APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_nslv #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 9,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      transfer,
    input  logic                      READ_WRITE,
    input  logic [ADDR_W-1:0]         apb_write_paddr,
    input  logic [ADDR_W-1:0]         apb_read_paddr,
    input  logic [DATA_W-1:0]         apb_write_data,
    output logic [DATA_W-1:0]         apb_read_data_out,
    output logic                      done,
    output logic                      err,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int SEL_W = $clog2(NUM_SLV);

    if (NUM_SLV < 2 || TIMEOUT < 1) begin : g_param_check
        $error("apb_master_nslv: NUM_SLV must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_dir, w_dir_nxt;
    logic [NUM_SLV-1:0]  w_psel_nxt, w_req_psel;
    logic                w_penable_nxt, w_pwrite_nxt, w_done_nxt, w_err_nxt;
    logic [ADDR_W-1:0]   w_paddr_nxt, w_req_addr;
    logic [DATA_W-1:0]   w_pwdata_nxt, w_rdata_nxt, w_prdata;
    logic [SEL_W-1:0]    w_idx;
    logic                w_ready, w_slverr, w_capture;

    // Only the slave addressed by the latched PADDR is observed.
    assign w_idx      = PADDR[ADDR_W-1 -: SEL_W];
    assign w_ready    = PREADY[w_idx];
    assign w_slverr   = PSLVERR[w_idx];
    assign w_prdata   = PRDATA[w_idx*DATA_W +: DATA_W];
    assign w_req_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;

    always_comb begin
        w_req_psel = '0;
        w_req_psel[w_req_addr[ADDR_W-1 -: SEL_W]] = 1'b1;
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir;
        w_psel_nxt    = PSEL;
        w_penable_nxt = PENABLE;
        w_pwrite_nxt  = PWRITE;
        w_paddr_nxt   = PADDR;
        w_pwdata_nxt  = PWDATA;
        w_rdata_nxt   = apb_read_data_out;
        w_done_nxt    = 1'b0;
        w_err_nxt     = err;
        w_capture     = 1'b0;
`ifdef APB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
                w_capture     = transfer;
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                w_cnt_nxt     = '0;
`endif
            end
            ST_ACCESS: begin
                if (w_ready) begin
                    w_done_nxt    = 1'b1;
                    w_err_nxt     = w_slverr;
                    if (r_dir && !w_slverr) begin
                        w_rdata_nxt = w_prdata;
                    end
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                    w_capture     = transfer;
`ifdef APB_TIMEOUT_EN
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This wait edge would bring the count to TIMEOUT: abort.
                    w_done_nxt    = 1'b1;
                    w_err_nxt     = 1'b1;
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt     = r_cnt + 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
            end
        endcase

        // New request captured from IDLE or on a completion edge (back-to-back).
        if (w_capture) begin
            w_dir_nxt     = READ_WRITE;
            w_paddr_nxt   = w_req_addr;
            w_pwdata_nxt  = apb_write_data;
            w_psel_nxt    = w_req_psel;
            w_pwrite_nxt  = ~READ_WRITE;
            w_penable_nxt = 1'b0;
            w_state_nxt   = ST_SETUP;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state           <= ST_IDLE;
            r_dir             <= 1'b0;
            PSEL              <= '0;
            PENABLE           <= 1'b0;
            PWRITE            <= 1'b0;
            PADDR             <= '0;
            PWDATA            <= '0;
            apb_read_data_out <= '0;
            done              <= 1'b0;
            err               <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_cnt             <= '0;
`endif
        end else begin
            r_state           <= w_state_nxt;
            r_dir             <= w_dir_nxt;
            PSEL              <= w_psel_nxt;
            PENABLE           <= w_penable_nxt;
            PWRITE            <= w_pwrite_nxt;
            PADDR             <= w_paddr_nxt;
            PWDATA            <= w_pwdata_nxt;
            apb_read_data_out <= w_rdata_nxt;
            done              <= w_done_nxt;
            err               <= w_err_nxt;
`ifdef APB_TIMEOUT_EN
            r_cnt             <= w_cnt_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_nslv.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_nslv
// Brief    : Directed bench for apb_master_nslv; completions are scored
//            against a queue of expected (err, read data) pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_nslv;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer;
    logic        READ_WRITE;
    logic [8:0]  apb_write_paddr;
    logic [8:0]  apb_read_paddr;
    logic [7:0]  apb_write_data;
    logic [7:0]  apb_read_data_out;
    logic        done;
    logic        err;
    logic [1:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [8:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [15:0] PRDATA;
    logic [1:0]  PREADY;
    logic [1:0]  PSLVERR;

    apb_master_nslv #(
        .DATA_W (8),
        .ADDR_W (9),
        .NUM_SLV(2),
        .TIMEOUT(16)
    ) dut (
        .PCLK             (PCLK),
        .PRESET           (PRESET),
        .transfer         (transfer),
        .READ_WRITE       (READ_WRITE),
        .apb_write_paddr  (apb_write_paddr),
        .apb_read_paddr   (apb_read_paddr),
        .apb_write_data   (apb_write_data),
        .apb_read_data_out(apb_read_data_out),
        .done             (done),
        .err              (err),
        .PSEL             (PSEL),
        .PENABLE          (PENABLE),
        .PWRITE           (PWRITE),
        .PADDR            (PADDR),
        .PWDATA           (PWDATA),
        .PRDATA           (PRDATA),
        .PREADY           (PREADY),
        .PSLVERR          (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic start(input logic rw, input logic [8:0] addr, input logic [7:0] data);
        transfer        = 1'b1;
        READ_WRITE      = rw;
        apb_read_paddr  = rw ? addr : 9'h1FF;
        apb_write_paddr = rw ? 9'h1FF : addr;
        apb_write_data  = data;
    endtask

    task automatic push(input logic e, input logic [7:0] d);
        exp_t x;
        x.err   = e;
        x.rdata = d;
        sb_q.push_back(x);
    endtask

    // Scoreboard monitor: every done pulse is matched against the queue.
    always @(negedge PCLK) begin
        if (!PRESET && done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_done: got done=1, expected no completion (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_err", {31'd0, err}, {31'd0, e.err});
                check("sb_rdata", {24'd0, apb_read_data_out}, {24'd0, e.rdata});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        PRESET = 1'b1; transfer = 1'b0; READ_WRITE = 1'b0;
        apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0;
        PRDATA = '0; PREADY = 2'b11; PSLVERR = 2'b00;
        tick(); tick();
        check("rst_psel", {30'd0, PSEL}, 32'd0);
        check("rst_penable", {31'd0, PENABLE}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", {24'd0, apb_read_data_out}, 32'd0);
        check("rst_paddr", {23'd0, PADDR}, 32'd0);
        PRESET = 1'b0;
        tick();

        // Zero-wait write to slave 0
        start(1'b0, 9'd5, 8'd55); push(1'b0, 8'd0);
        tick(); transfer = 1'b0;
        check("t1_psel", {30'd0, PSEL}, 32'd1);
        check("t1_penable_setup", {31'd0, PENABLE}, 32'd0);
        check("t1_pwrite", {31'd0, PWRITE}, 32'd1);
        check("t1_paddr", {23'd0, PADDR}, 32'd5);
        tick();
        check("t1_penable_access", {31'd0, PENABLE}, 32'd1);
        check("t1_pwdata", {24'd0, PWDATA}, 32'd55);
        check("t1_done_early", {31'd0, done}, 32'd0);
        tick();
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_psel_idle", {30'd0, PSEL}, 32'd0);
        tick();
        check("t1_done_pulse", {31'd0, done}, 32'd0);

        // Write to slave 1; user inputs change after capture
        start(1'b0, 9'd260, 8'd123); push(1'b0, 8'd0);
        tick(); transfer = 1'b0; apb_write_data = 8'hAA; apb_write_paddr = 9'd0;
        check("t2_psel", {30'd0, PSEL}, 32'd2);
        check("t2_paddr", {23'd0, PADDR}, 32'd260);
        tick();
        check("t2_pwdata_stable", {24'd0, PWDATA}, 32'd123);
        check("t2_paddr_stable", {23'd0, PADDR}, 32'd260);
        tick();
        check("t2_done", {31'd0, done}, 32'd1);
        tick();

        // Read back from slave 1; slave 0 data must be ignored
        PRDATA = {8'd123, 8'hEE};
        start(1'b1, 9'd260, 8'd0); push(1'b0, 8'd123);
        tick(); transfer = 1'b0;
        check("t3_psel", {30'd0, PSEL}, 32'd2);
        check("t3_pwrite", {31'd0, PWRITE}, 32'd0);
        tick(); tick();
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_rdata", {24'd0, apb_read_data_out}, 32'd123);
        tick();

        // Read from slave 0 with three wait states
        PRDATA = {8'h11, 8'h3C}; PREADY = 2'b10;
        start(1'b1, 9'd10, 8'd0); push(1'b0, 8'h3C);
        tick(); transfer = 1'b0;
        check("t4_psel", {30'd0, PSEL}, 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("t4_penable_wait", {31'd0, PENABLE}, 32'd1);
            check("t4_paddr_wait", {23'd0, PADDR}, 32'd10);
            check("t4_no_done", {31'd0, done}, 32'd0);
            if (k == 5) PREADY = 2'b11;
        end
        tick();
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_rdata", {24'd0, apb_read_data_out}, 32'h3C);
        tick();

        // Erroring read on slave 1 followed back-to-back by a write to slave 0
        PSLVERR = 2'b10; PRDATA = {8'h77, 8'h00};
        start(1'b1, 9'd300, 8'd0); push(1'b1, 8'h3C); push(1'b0, 8'h3C);
        tick();
        check("t5_psel", {30'd0, PSEL}, 32'd2);
        tick();
        start(1'b0, 9'd5, 8'd99);
        tick();
        check("t5_done_err", {31'd0, done}, 32'd1);
        check("t5_err", {31'd0, err}, 32'd1);
        check("t5_rdata_kept", {24'd0, apb_read_data_out}, 32'h3C);
        check("t5_b2b_psel", {30'd0, PSEL}, 32'd1);
        check("t5_b2b_penable", {31'd0, PENABLE}, 32'd0);
        check("t5_b2b_paddr", {23'd0, PADDR}, 32'd5);
        transfer = 1'b0; PSLVERR = 2'b00;
        tick();
        check("t5_penable", {31'd0, PENABLE}, 32'd1);
        check("t5_pwdata", {24'd0, PWDATA}, 32'd99);
        check("t5_err_held", {31'd0, err}, 32'd1);
        tick();
        check("t5_done2", {31'd0, done}, 32'd1);
        check("t5_err2", {31'd0, err}, 32'd0);
        tick();

        // Reset during a wait state
        PREADY = 2'b00;
        start(1'b1, 9'd10, 8'd0);
        tick(); transfer = 1'b0;
        tick(); tick();
        check("t6_waiting", {31'd0, PENABLE}, 32'd1);
        PRESET = 1'b1;
        tick();
        check("t6_psel", {30'd0, PSEL}, 32'd0);
        check("t6_penable", {31'd0, PENABLE}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_rdata", {24'd0, apb_read_data_out}, 32'd0);
        PRESET = 1'b0; PREADY = 2'b11;
        tick(); tick();
        check("t6_idle_psel", {30'd0, PSEL}, 32'd0);
        check("t6_idle_done", {31'd0, done}, 32'd0);

        // PREADY held low: default build waits indefinitely
        PREADY = 2'b00;
        start(1'b1, 9'd10, 8'd0);
        tick(); transfer = 1'b0;
        nd = 0;
        repeat (50) begin
            tick();
            if (done) nd++;
        end
        check("t7_no_timeout_done", nd, 32'd0);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0; PREADY = 2'b11;
        repeat (3) tick();

        check("sb_queue_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_nslv.md
Name: apb_master_nslv

Overview:
Parametrised APB master bridge, successor to the fixed 8-bit/9-bit, two-slave APB top.
- Converts a simple user request (transfer, READ_WRITE, address, data) into APB SETUP/ACCESS phases.
- Decodes NUM_SLV slaves from the address MSBs.
- Adds what the earlier block lacked: wait states via PREADY, slave errors via PSLVERR, a completion pulse, and back-to-back transfers.

Parameters:
- DATA_W, 8, width of PWDATA, PRDATA and user data.
- ADDR_W, 9, width of the user address and PADDR.
- NUM_SLV, 2, number of slaves; power of 2, at least 2. SEL_W = clog2(NUM_SLV).
- TIMEOUT, 16, maximum wait-state cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock, all logic on rising edge.
- PRESET  in  1  synchronous active-high reset.
- transfer  in  1  request; sampled only in IDLE or on an ACCESS completion edge.
- READ_WRITE  in  1  1 = read, 0 = write.
- apb_write_paddr  in  ADDR_W  write address.
- apb_read_paddr  in  ADDR_W  read address.
- apb_write_data  in  DATA_W  write data.
- apb_read_data_out  out  DATA_W  last read data, held until the next read completes.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  error status of the completed transfer; valid with done and held until the next done.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  ACCESS phase indicator.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  full latched address.
- PWDATA  out  DATA_W  latched write data.
- PRDATA  in  NUM_SLV*DATA_W  slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

Behaviour:
- Clocking and reset: one clock, PCLK. PRESET is synchronous and active-high, and takes priority over everything, including a transfer mid-ACCESS. At the edge where PRESET is high:
  - state goes to IDLE;
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, apb_read_data_out, done and err all go to 0;
  - the timeout counter clears.
- Outputs: all registered. No combinational path from inputs to outputs.
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - If transfer = 1 at an edge, capture dir = READ_WRITE, PADDR = (READ_WRITE ? apb_read_paddr : apb_write_paddr), and PWDATA = apb_write_data. Go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL[idx] = 1, where idx = PADDR[ADDR_W-1 -: SEL_W]. PENABLE = 0. PWRITE = ~dir.
  - Next state is always ACCESS.
- ACCESS:
  - PENABLE = 1. PSEL, PADDR, PWRITE and PWDATA are held stable.
  - Only PREADY[idx], PSLVERR[idx] and PRDATA[idx] are observed; other slaves' signals are ignored.
  - At an edge with PREADY[idx] = 1, complete the transfer:
    - done = 1 for one cycle and err = PSLVERR[idx];
    - on a read with no error, apb_read_data_out = PRDATA[idx];
    - on a read with error, or on any write, apb_read_data_out keeps its value.
  - Next state after completion: if transfer = 1 on that same edge, capture the new request and go to SETUP (back-to-back; no IDLE cycle, PENABLE drops). Otherwise go to IDLE.
  - If PREADY[idx] = 0, stay in ACCESS (wait state).
- Latency: with a zero-wait slave, transfer sampled at edge 0 gives SETUP at edge 1, ACCESS at edge 2, and done at edge 3. Each wait cycle adds 1. Back-to-back throughput is one transfer per 2 cycles.
- Input stability: user inputs that change after capture do not affect the transfer in flight.
- Decode: the full PADDR, including the select bits, is driven to the slave.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments on each ACCESS edge with PREADY[idx] = 0.
  - When the counter reaches TIMEOUT, the transfer aborts on that edge: done = 1, err = 1, apb_read_data_out unchanged, state goes to IDLE, and transfer is ignored on that edge.
  - A PREADY that arrives on the same edge the counter hits TIMEOUT wins: the transfer completes normally.
- Not defined: no counter exists, and ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset and zero-wait write: PRESET = 1 for 2 cycles, then a write to addr 5 with data 55 → PSEL = 01 at +1, PENABLE at +2, PWDATA = 55, PADDR = 5, done at +3 with err = 0.
- Slave decode: write 9'd260 with data 123, then read 9'd260 with slave 1 returning 123 → PSEL = 10 for both; apb_read_data_out = 123 at done; slave 0 PRDATA is ignored.
- Wait states: read addr 10 with PREADY[0] low for 3 cycles → PENABLE high for 4 cycles, done at +6, PADDR stable throughout.
- Error and back-to-back: with PSLVERR[1] = 1, read 300 while transfer stays high; the next request is a write to 5 with data 99 → first done has err = 1 and apb_read_data_out unchanged; SETUP follows immediately; second done has err = 0.
- Reset mid-ACCESS: assert PRESET during a wait state → next edge shows PSEL = 0, PENABLE = 0, done = 0, and the block returns to IDLE.
- APB_TIMEOUT_EN with TIMEOUT = 4 and PREADY held low → done = 1 and err = 1 after 4 wait cycles, then IDLE. Without the macro, no done appears within 50 cycles.
